// File: rtl/mm_bram_loader.sv
`default_nettype none
// mm_bram_loader: port-A sequencer for the Montgomery multiplier bridge BRAM.
// Loads p_prime_0/p/a/b, kicks the multiplier, then streams the s result words out with backpressure.
module mm_bram_loader #(
  parameter int s            = 8,
  parameter int BRAM_LATENCY = 1,
  parameter int RES_BASE     = 0,
  localparam int ADDR_W      = $clog2(4*s)
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [16:0]       op_data_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  output logic [16:0]       res_data_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_last_o,
  output logic              mm_start_o,
  input  logic              mm_done_i,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [16:0]       bram_din_o,
  output logic              bram_we_o,
  output logic              bram_en_o,
  input  logic [16:0]       bram_dout_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    KICK     = 3'd1,
    WAIT_MM  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_HOLD  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(3*s);
  localparam logic [ADDR_W-1:0] LAST_RES  = ADDR_W'(s-1);
  localparam logic [ADDR_W-1:0] RES_ADDR0 = ADDR_W'(RES_BASE);
  localparam logic [1:0]        LAT_LAST  = 2'(BRAM_LATENCY-1);

  if (s < 2) begin : g_bad_s
    $error("mm_bram_loader: s must be at least 2");
  end
  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 3) begin : g_bad_latency
    $error("mm_bram_loader: BRAM_LATENCY must be 1..3");
  end
  if (RES_BASE < 0 || RES_BASE + s - 1 >= 4*s) begin : g_bad_res_base
    $error("mm_bram_loader: result window exceeds the BRAM address range");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wcnt, rcnt;
  logic [1:0]        lat_cnt;
  logic              res_hs, lat_done;

  assign res_hs   = res_valid_o & res_ready_i;
  assign lat_done = (lat_cnt == LAT_LAST);
  // wcnt is non-zero only after the first accepted word of a load
  assign busy_o   = (state != LOAD) || (wcnt != '0);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= LOAD;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    op_ready_o  = 1'b0;
    mm_start_o  = 1'b0;
    bram_en_o   = 1'b0;
    bram_we_o   = 1'b0;
    bram_addr_o = '0;
    bram_din_o  = '0;
    case (state)
      LOAD: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          bram_en_o   = 1'b1;
          bram_we_o   = 1'b1;
          bram_addr_o = wcnt;
          bram_din_o  = op_data_i;
          if (wcnt == LAST_WORD) state_nxt = KICK;
        end
      end
      KICK: begin
        mm_start_o = 1'b1;
        state_nxt  = WAIT_MM;
      end
      WAIT_MM: begin
        if (mm_done_i) state_nxt = RD_ISSUE;
      end
      RD_ISSUE: begin
        bram_en_o   = 1'b1;
        bram_addr_o = RES_ADDR0 + rcnt;
        state_nxt   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_done) state_nxt = RD_HOLD;
      end
      RD_HOLD: begin
        if (res_hs) state_nxt = (rcnt == LAST_RES) ? LOAD : RD_ISSUE;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wcnt        <= '0;
      rcnt        <= '0;
      lat_cnt     <= '0;
      res_data_o  <= '0;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
    end else begin
      if (state == LOAD && op_valid_i)
        wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + 1'b1;
      if (state == RD_WAIT) begin
        if (lat_done) begin
          lat_cnt     <= '0;
          res_data_o  <= bram_dout_i;
          res_valid_o <= 1'b1;
          res_last_o  <= (rcnt == LAST_RES);
        end else begin
          lat_cnt <= lat_cnt + 2'd1;
        end
      end
      // data stays put after the handshake; only valid/last drop
      if (state == RD_HOLD && res_hs) begin
        res_valid_o <= 1'b0;
        res_last_o  <= 1'b0;
        rcnt        <= (rcnt == LAST_RES) ? '0 : rcnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_bram_loader.sv
`default_nettype none
// tb_mm_bram_loader: two DUTs (BRAM latency 1 and 3) with behavioural dual-port BRAMs and multiplier model.
module tb_mm_bram_loader;
  localparam int S  = 8;
  localparam int N  = 3*S + 1;
  localparam int AW = 5;

  logic clk, rst_n, sel;
  logic [16:0] op_data;
  logic op_valid, res_ready, mm_done;
  logic pb_we;
  logic [AW-1:0] pb_addr;
  logic [16:0] pb_din;

  logic a_op_ready, a_res_valid, a_res_last, a_mm_start, a_we, a_en, a_busy;
  logic b_op_ready, b_res_valid, b_res_last, b_mm_start, b_we, b_en, b_busy;
  logic [16:0] a_res_data, a_din, a_dout, b_res_data, b_din, b_dout;
  logic [AW-1:0] a_addr, b_addr;

  logic op_ready, res_valid, res_last, mm_start, bram_we, bram_en, busy;
  logic [16:0] res_data, bram_din;
  logic [AW-1:0] bram_addr;

  assign op_ready  = sel ? b_op_ready  : a_op_ready;
  assign res_valid = sel ? b_res_valid : a_res_valid;
  assign res_last  = sel ? b_res_last  : a_res_last;
  assign res_data  = sel ? b_res_data  : a_res_data;
  assign mm_start  = sel ? b_mm_start  : a_mm_start;
  assign bram_we   = sel ? b_we        : a_we;
  assign bram_en   = sel ? b_en        : a_en;
  assign bram_addr = sel ? b_addr      : a_addr;
  assign bram_din  = sel ? b_din       : a_din;
  assign busy      = sel ? b_busy      : a_busy;

  mm_bram_loader #(.s(S), .BRAM_LATENCY(1), .RES_BASE(0)) dut_a (
    .clock_i(clk), .reset_n_i(rst_n),
    .op_data_i(op_data), .op_valid_i(op_valid & ~sel), .op_ready_o(a_op_ready),
    .res_data_o(a_res_data), .res_valid_o(a_res_valid), .res_ready_i(res_ready & ~sel),
    .res_last_o(a_res_last), .mm_start_o(a_mm_start), .mm_done_i(mm_done & ~sel),
    .bram_addr_o(a_addr), .bram_din_o(a_din), .bram_we_o(a_we), .bram_en_o(a_en),
    .bram_dout_i(a_dout), .busy_o(a_busy));

  mm_bram_loader #(.s(S), .BRAM_LATENCY(3), .RES_BASE(0)) dut_b (
    .clock_i(clk), .reset_n_i(rst_n),
    .op_data_i(op_data), .op_valid_i(op_valid & sel), .op_ready_o(b_op_ready),
    .res_data_o(b_res_data), .res_valid_o(b_res_valid), .res_ready_i(res_ready & sel),
    .res_last_o(b_res_last), .mm_start_o(b_mm_start), .mm_done_i(mm_done & sel),
    .bram_addr_o(b_addr), .bram_din_o(b_din), .bram_we_o(b_we), .bram_en_o(b_en),
    .bram_dout_i(b_dout), .busy_o(b_busy));

  // Behavioural true dual-port BRAMs: port A from the DUT, port B from the multiplier model
  logic [16:0] mem_a [32];
  logic [16:0] mem_b [32];
  logic [16:0] pipe_a;
  logic [16:0] pipe_b [3];

  always @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem_a[a_addr] <= a_din;
      pipe_a <= mem_a[a_addr];
    end
    if (pb_we && !sel) mem_a[pb_addr] <= pb_din;
  end
  assign a_dout = pipe_a;

  always @(posedge clk) begin
    if (b_en) begin
      if (b_we) mem_b[b_addr] <= b_din;
      pipe_b[0] <= mem_b[b_addr];
    end
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (pb_we && sel) mem_b[pb_addr] <= pb_din;
  end
  assign b_dout = pipe_b[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [16:0] ops [N];
  logic [16:0] res_exp [S];

  task automatic fill(input bit pattern);
    for (int i = 0; i < N; i++) ops[i] = pattern ? 17'(i) : 17'($urandom);
    for (int i = 0; i < S; i++) res_exp[i] = pattern ? 17'(32'h1A000 + i) : 17'($urandom);
  endtask

  task automatic load_words(input int gap, input int done_at, input int abort_at);
    int i = 0;
    int cyc = 0;
    logic [AW-1:0] ea;
    while (i < N && cyc < 400) begin
      if (i == abort_at) begin
        op_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || mm_start !== 1'b0 || bram_en !== 1'b0)
          begin errors++; $display("FAIL load_reset ready=%b busy=%b valid=%b start=%b en=%b required 1 0 0 0 0",
                                   op_ready, busy, res_valid, mm_start, bram_en); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      op_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, gap) == 0);
      op_data  = ops[i];
      mm_done  = (i == done_at);
      ea = AW'(i);
      #1;
      checks++;
      if (op_ready !== 1'b1 || bram_en !== op_valid || bram_we !== op_valid ||
          (op_valid && (bram_addr !== ea || bram_din !== ops[i])))
        begin errors++; $display("FAIL load_write word=%0d ready=%b en=%b we=%b addr=%0d din=%h required addr=%0d din=%h",
                                 i, op_ready, bram_en, bram_we, bram_addr, bram_din, ea, ops[i]); end
      @(posedge clk); #1;
      mm_done = 1'b0;
      if (op_valid) i++;
      cyc++;
    end
    op_valid = 1'b0;
    if (i < N) begin
      checks++; errors++;
      $display("FAIL load_timeout words=%0d required %0d", i, N);
    end
  endtask

  task automatic do_mm();
    int bad = 0;
    checks++;
    if (mm_start !== 1'b1 || op_ready !== 1'b0 || bram_en !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL kick start=%b ready=%b en=%b busy=%b required 1 0 0 1",
                               mm_start, op_ready, bram_en, busy); end
    for (int i = 0; i < N; i++) if ((sel ? mem_b[i] : mem_a[i]) !== ops[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bram_contents wrong_words=%0d required 0", bad); end
    @(posedge clk); #1;
    for (int i = 0; i < S; i++) begin
      op_valid = 1'($urandom);
      pb_we = 1'b1; pb_addr = AW'(i); pb_din = res_exp[i];
      #1;
      checks++;
      if (mm_start !== 1'b0 || op_ready !== 1'b0 || bram_en !== 1'b0 || bram_we !== 1'b0)
        begin errors++; $display("FAIL wait_mm start=%b ready=%b en=%b we=%b required 0 0 0 0",
                                 mm_start, op_ready, bram_en, bram_we); end
      @(posedge clk); #1;
    end
    pb_we = 1'b0; op_valid = 1'b0;
    mm_done = 1'b1;
    @(posedge clk); #1;
    mm_done = 1'b0;
  endtask

  task automatic read_results(input int mode, input int done_at, input int abort_at);
    int idx = 0, cyc = 0, hs_cyc = 0, stall = 0, lat, exp_cyc;
    bit pv = 0, phs = 0, pl = 0, hs, done_sent = 0;
    logic [16:0] pd = '0;
    logic [AW-1:0] ea;
    lat = sel ? 3 : 1;
    while (idx < S && cyc < 600) begin
      ea = AW'(idx);
      checks++;
      if ((pv && !phs && (res_valid !== 1'b1 || res_data !== pd || res_last !== pl)) || (phs && res_valid !== 1'b0))
        begin errors++; $display("FAIL res_stable word=%0d valid=%b data=%h last=%b required valid=%b data=%h last=%b",
                                 idx, res_valid, res_data, res_last, !phs, pd, pl); end
      checks++;
      if (bram_we !== 1'b0 || op_ready !== 1'b0 || busy !== 1'b1 || (bram_en && bram_addr !== ea))
        begin errors++; $display("FAIL read_port word=%0d we=%b ready=%b busy=%b en=%b addr=%0d required 0 0 1 addr=%0d",
                                 idx, bram_we, op_ready, busy, bram_en, bram_addr, ea); end
      if (res_valid && !pv) begin
        exp_cyc = (idx == 0) ? lat + 1 : hs_cyc + lat + 2;
        checks++;
        if (cyc != exp_cyc) begin errors++;
          $display("FAIL res_latency word=%0d cycle=%0d required %0d", idx, cyc, exp_cyc); end
      end
      if (idx == abort_at && res_valid) begin
        res_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_last !== 1'b0 || busy !== 1'b0 || bram_en !== 1'b0)
          begin errors++; $display("FAIL read_reset ready=%b valid=%b last=%b busy=%b en=%b required 1 0 0 0 0",
                                   op_ready, res_valid, res_last, busy, bram_en); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (mode == 0) res_ready = 1'b1;
      else if (stall > 0) begin res_ready = 1'b0; stall--; end
      else res_ready = ($urandom_range(0, 2) == 0);
      if (mode != 0 && res_valid && !pv && (idx == 3 || idx == 6)) begin res_ready = 1'b0; stall = 9; end
      if (idx == done_at && res_valid && !done_sent) begin mm_done = 1'b1; res_ready = 1'b0; done_sent = 1; end
      hs = res_valid && res_ready;
      if (hs) begin
        checks++;
        if (res_data !== res_exp[idx] || res_last !== (idx == S-1))
          begin errors++; $display("FAIL res_data word=%0d data=%h last=%b required data=%h last=%b",
                                   idx, res_data, res_last, res_exp[idx], idx == S-1); end
      end
      pv = res_valid; pd = res_data; pl = res_last; phs = hs;
      @(posedge clk); #1;
      mm_done = 1'b0;
      if (hs) begin hs_cyc = cyc; idx++; end
      cyc++;
    end
    res_ready = 1'b0;
    checks++;
    if (idx < S) begin errors++; $display("FAIL read_timeout words=%0d required %0d", idx, S); end
    else if (res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1)
      begin errors++; $display("FAIL read_end valid=%b busy=%b ready=%b required 0 0 1", res_valid, busy, op_ready); end
  endtask

  task automatic run_full(input bit pattern, input int gap, input int mode);
    fill(pattern);
    load_words(gap, -1, -1);
    do_mm();
    read_results(mode, -1, -1);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_last !== 1'b0 || res_data !== 17'h0 || mm_start !== 1'b0 ||
        bram_en !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== 17'h0 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_state ready=%b valid=%b last=%b data=%h start=%b en=%b we=%b addr=%0d din=%h busy=%b required ready=1 rest 0",
                               op_ready, res_valid, res_last, res_data, mm_start, bram_en, bram_we, bram_addr, bram_din, busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_and_readback();
    run_full(1'b1, 0, 0);
  endtask

  task automatic test_backpressure();
    run_full(1'b0, 2, 1);
  endtask

  task automatic test_done_ignored();
    fill(1'b0);
    load_words(0, 10, -1);
    do_mm();
    read_results(1, 2, -1);
  endtask

  task automatic test_reset_midway();
    fill(1'b0);
    load_words(0, -1, 12);
    load_words(1, -1, -1);
    do_mm();
    read_results(0, -1, 4);
    run_full(1'b0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_full(1'b0, 0, 0);
    run_full(1'b0, 0, 1);
    sel = 1'b1;
    run_full(1'b0, 0, 0);
    run_full(1'b0, 1, 1);
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; op_data = '0; op_valid = 1'b0; res_ready = 1'b0; mm_done = 1'b0;
    pb_we = 1'b0; pb_addr = '0; pb_din = '0;
    test_reset();
    test_load_and_readback();
    test_backpressure();
    test_done_ignored();
    test_reset_midway();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
